// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter
// Owns the single-port tile RAM of the snake playfield. The VGA scan-out
// path has absolute priority; the game writer only gets the port during
// blanking. Also generates the frame and game-step ticks.
//
// Ports
//   clk_vga, rst_n          pixel clock, async active-low reset
//   vga_xpos, vga_ypos      1-based pixel position from vga_driver, 0 = blank
//   wr_req/wr_addr/wr_code  game writer request, held until wr_ack
//   wr_ack                  request consumed this cycle
//   ram_addr/ram_we/ram_wdata  RAM port, sampled by the RAM on the next edge
//   ram_rdata               RAM read data, one cycle after the address
//   pix_code                tile code of the pixel being displayed, 0 when blank
//   speed                   frames per game step minus 1
//   frame_tick, game_tick   pacing pulses
module tile_ram_arbiter #(
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int TILE_SHIFT = 4,
  parameter int H_BLANK    = 160,
  parameter int ADDR_W     = 11,
  parameter int CODE_W     = 2
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic [9:0]        vga_xpos,
  input  logic [9:0]        vga_ypos,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata,
  output logic [CODE_W-1:0] pix_code,
  input  logic [3:0]        speed,
  output logic              frame_tick,
  output logic              game_tick
);

  localparam logic [7:0]        BCNT_MAX   = 8'(H_BLANK - 1);
  localparam logic [9:0]        COL_MAX    = 10'(GRID_W - 1);
  localparam logic [ADDR_W-1:0] TILE_CNT   = ADDR_W'(GRID_W * GRID_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(GRID_W);

  logic [7:0]        bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_valid;
  logic              ypos_nz_q;
  logic              spd_ld;
  logic [3:0]        fcnt;
  logic [3:0]        spd_l;

  logic              x_act;
  logic              y_act;
  logic              is_disp;
  logic              is_guard;
  logic [9:0]        row;
  logic [9:0]        col_raw;
  logic [9:0]        col;
  logic [ADDR_W-1:0] row_base;

  assign x_act    = (vga_xpos != 10'd0);
  assign y_act    = (vga_ypos != 10'd0);
  assign is_disp  = x_act && y_act;
  // Last blanking cycle of a visible line prefetches tile column 0.
  assign is_guard = !x_act && y_act && (bcnt == BCNT_MAX);

  assign row      = (vga_ypos - 10'd1) >> TILE_SHIFT;
  assign col_raw  = vga_xpos >> TILE_SHIFT;
  // xpos runs one pixel ahead, so xpos=640 would address column 40.
  assign col      = (col_raw > COL_MAX) ? COL_MAX : col_raw;
  assign row_base = ADDR_W'(row) * ROW_STRIDE;

  // Port mux. Gated by rst_n so a write in flight drops the instant reset hits.
  always_comb begin
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    wr_ack    = 1'b0;
    if (!rst_n) begin
      ram_addr = '0;
    end else if (is_disp) begin
      ram_addr = row_base + ADDR_W'(col);
    end else if (is_guard) begin
      ram_addr = row_base;
    end else if (wr_req) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_code;
      wr_ack    = 1'b1;
      ram_we    = (wr_addr < TILE_CNT);
    end
  end

  assign pix_code   = rd_valid ? ram_rdata : '0;
  assign frame_tick = ypos_nz_q && !y_act;
  assign game_tick  = frame_tick && (fcnt == spd_l);

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      bcnt      <= 8'd0;
      addr_q    <= '0;
      rd_valid  <= 1'b0;
      ypos_nz_q <= 1'b0;
      spd_ld    <= 1'b1;
      fcnt      <= 4'd0;
      spd_l     <= 4'd0;
    end else begin
      if (x_act)
        bcnt <= 8'd0;
      else if (bcnt != BCNT_MAX)
        bcnt <= bcnt + 8'd1;

      addr_q    <= ram_addr;
      rd_valid  <= is_disp || is_guard;
      ypos_nz_q <= y_act;

      // spd_ld is high only for the first cycle after reset release.
      spd_ld <= 1'b0;
      if (spd_ld || game_tick)
        spd_l <= speed;

      if (frame_tick)
        fcnt <= game_tick ? 4'd0 : fcnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_tile_ram_arbiter.sv
module tb_tile_ram_arbiter;

  localparam int W = 40;

  logic        clk_vga = 1'b0;
  logic        rst_n;
  logic [9:0]  vga_xpos, vga_ypos;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [1:0]  wr_code;
  logic        wr_ack;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic [1:0]  pix_code;
  logic [3:0]  speed;
  logic        frame_tick, game_tick;

  always #5 clk_vga = ~clk_vga;

  tile_ram_arbiter dut (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .vga_xpos(vga_xpos), .vga_ypos(vga_ypos),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_code(wr_code), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_code(pix_code), .speed(speed),
    .frame_tick(frame_tick), .game_tick(game_tick)
  );

  // Synchronous single-port RAM, registered read.
  logic [1:0] mem [0:2047];
  always @(posedge clk_vga) begin
    if (!rst_n) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 2'd0;
      ram_rdata <= 2'd0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  int shadow [0:2047];
  int qa[$];
  int qc[$];
  logic        nreq;
  logic [10:0] naddr;
  logic [1:0]  ncode;
  int  exp_hold;
  int  rd_addr;
  bit  prev_rd;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input int x, input int y);
    @(posedge clk_vga);
    #1;
    vga_xpos = 10'(x);
    vga_ypos = 10'(y);
    wr_req   = nreq;
    wr_addr  = naddr;
    wr_code  = ncode;
    #1;
  endtask

  task automatic next_req();
    if (qa.size() > 0) begin
      nreq  = 1'b1;
      naddr = 11'(qa.pop_front());
      ncode = 2'(qc.pop_front());
    end else begin
      nreq = 1'b0;
    end
  endtask

  // Hand-computed pixel expectations from the preload pattern.
  function automatic int plan_pix(input int y, input int p);
    if (y == 1)  return (p < 16) ? 1 : (p < 32) ? 2 : 0;
    if (y == 17) return (p < 32) ? 3 : 0;
    if (y == 33) return (p >= 320 && p < 336) ? 1 : 0;
    if (y == 81) return (p < 16) ? 2 : 0;
    return -1;
  endfunction

  task automatic hblank(input int y, input int req_at, input bit chain);
    int base = ((y - 1) >> 4) * W;
    for (int b = 0; b < 160; b++) begin
      bit exp_ack;
      int exp_pix;
      if (b == req_at) next_req();
      exp_pix = prev_rd ? shadow[rd_addr] : 0;
      cyc(0, y);
      exp_ack = nreq && (b != 159);
      check("blank_pix", pix_code, exp_pix);
      check("blank_ack", wr_ack, exp_ack);
      check("blank_we", ram_we, exp_ack && (naddr < 11'd1200));
      if (exp_ack) begin
        check("wr_addr", ram_addr, naddr);
        check("wr_data", ram_wdata, ncode);
        if (naddr < 11'd1200) shadow[naddr] = ncode;
        exp_hold = naddr;
      end else if (b == 159) begin
        check("guard_addr", ram_addr, base);
        exp_hold = base;
      end else begin
        check("hold_addr", ram_addr, exp_hold);
      end
      prev_rd = (b == 159);
      rd_addr = base;
      if (exp_ack) begin
        if (chain) next_req();
        else nreq = 1'b0;
      end
    end
  endtask

  task automatic active_line(input int y, input int req_x);
    int base = ((y - 1) >> 4) * W;
    for (int x = 1; x <= 640; x++) begin
      int exp_pix, a, pp;
      if (x == req_x) next_req();
      exp_pix = prev_rd ? shadow[rd_addr] : 0;
      a  = base + (((x >> 4) > 39) ? 39 : (x >> 4));
      pp = plan_pix(y, x - 1);
      cyc(x, y);
      check("disp_addr", ram_addr, a);
      check("disp_we", ram_we, 0);
      check("disp_ack", wr_ack, 0);
      check("pix", pix_code, exp_pix);
      if (pp >= 0) check("plan_pix", pix_code, pp);
      prev_rd  = 1'b1;
      rd_addr  = a;
      exp_hold = a;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) shadow[i] = 0;
    nreq = 1'b0; naddr = '0; ncode = '0;
    exp_hold = 0; rd_addr = 0; prev_rd = 1'b0;

    // Reset with a write pending: nothing may leak out.
    rst_n = 1'b0; wr_req = 1'b1; wr_addr = 11'd5; wr_code = 2'd1;
    vga_xpos = 10'd0; vga_ypos = 10'd0; speed = 4'd2;
    repeat (2) @(posedge clk_vga);
    #1 vga_ypos = 10'd1;
    #1;
    check("rst_we", ram_we, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_pix", pix_code, 0);
    @(posedge clk_vga);
    #1 vga_ypos = 10'd0;
    #1;
    check("rst_frame_tick", frame_tick, 0);
    check("rst_game_tick", game_tick, 0);
    @(posedge clk_vga);
    #1 rst_n = 1'b1; wr_req = 1'b0;

    // speed=2: game_tick on every third frame_tick.
    for (int f = 1; f <= 9; f++) begin
      for (int k = 0; k < 4; k++) begin
        cyc(0, 1);
        check("ft_idle", frame_tick, 0);
      end
      cyc(0, 0);
      check("frame_tick", frame_tick, 1);
      check("game_tick", game_tick, (f % 3 == 0) ? 1 : 0);
      cyc(0, 0);
      check("ft_once", frame_tick, 0);
      check("gt_once", game_tick, 0);
      cyc(0, 0);
    end

    // One active cycle so bcnt starts the first line from 0.
    cyc(1, 0);

    // Writes at bcnt=10, back-to-back, including an out-of-range one.
    qa = {41, 0, 1, 40, 1200};
    qc = {3, 1, 2, 3, 2};
    hblank(1, 10, 1'b1);
    active_line(1, 0);
    hblank(17, -1, 1'b0);
    active_line(17, 0);

    // Request during display waits for blanking.
    hblank(20, -1, 1'b0);
    qa = {100};
    qc = {1};
    active_line(20, 5);

    // Request raised exactly in the guard cycle waits a whole line.
    qa = {200};
    qc = {2};
    hblank(21, 159, 1'b0);
    active_line(21, 0);
    hblank(22, -1, 1'b0);
    active_line(22, 0);

    hblank(33, -1, 1'b0);
    active_line(33, 0);
    hblank(81, -1, 1'b0);
    active_line(81, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
